// File: rtl/arbitro_pkg.sv
// Shared types and default sizing for the round-robin FIFO write arbiter.
package arbitro_pkg;

    typedef enum logic {
        LIVRE  = 1'b0,
        RAJADA = 1'b1
    } estado_t;

    localparam int N_REQ_PADRAO      = 4;
    localparam int LARGURA_PADRAO    = 8;
    localparam int MAX_RAJADA_PADRAO = 4;

    function automatic int proximo(input int i, input int n);
        return (i + 1 >= n) ? 0 : i + 1;
    endfunction

endpackage

// File: rtl/rr_prioridade.sv
// Rotating priority encoder: first set request at or after inicio, modulo N_REQ.
module rr_prioridade #(
    parameter int N_REQ = 4,
    parameter int IW    = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IW-1:0]    inicio,
    output logic             valido,
    output logic [IW-1:0]    vencedor
);

    int k;

    // Scan from the far end so the candidate closest to inicio wins.
    always_comb begin
        valido   = |req;
        vencedor = '0;
        k        = 0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            k = int'(inicio) + i;
            if (k >= N_REQ)
                k = k - N_REQ;
            if (req[IW'(k)])
                vencedor = IW'(k);
        end
    end

endmodule

// File: rtl/fifo_arbitro_rr.sv
// Round-robin arbiter with bounded bursts feeding a single FIFO write port.
module fifo_arbitro_rr
    import arbitro_pkg::*;
#(
    parameter int N_REQ      = N_REQ_PADRAO,
    parameter int LARGURA    = LARGURA_PADRAO,
    parameter int MAX_RAJADA = MAX_RAJADA_PADRAO
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [N_REQ-1:0]                req,
    input  logic [N_REQ-1:0][LARGURA-1:0]   dado_req,
    output logic [N_REQ-1:0]                ack,
    input  logic                            fila_cheia,
    output logic                            carregar_data,
    output logic [LARGURA-1:0]              data_ent,
    output logic [$clog2(N_REQ)-1:0]        concedido,
    output logic [15:0]                     contagem_escritas
);

    localparam int IW = $clog2(N_REQ);

    estado_t       estado;
    logic [IW-1:0] ptr;
    logic [IW-1:0] dono;
    logic [3:0]    cnt;

    logic [IW-1:0] inicio;
    logic [IW-1:0] vencedor;
    logic [IW-1:0] dono_prox;
    logic [IW-1:0] venc_prox;
    logic [IW-1:0] idx;
    logic          valido;
    logic          fica_dono;
    logic          grant;

    assign dono_prox = IW'(proximo(int'(dono), N_REQ));
    assign venc_prox = IW'(proximo(int'(vencedor), N_REQ));
    assign fica_dono = (estado == RAJADA) && req[dono];

    // An idle burst owner hands over immediately, scanning from the next slot.
    assign inicio = (estado == RAJADA) ? dono_prox : ptr;

    rr_prioridade #(
        .N_REQ    (N_REQ),
        .IW       (IW)
    ) u_rr (
        .req      (req),
        .inicio   (inicio),
        .valido   (valido),
        .vencedor (vencedor)
    );

    assign grant = !rst && !fila_cheia && (fica_dono || valido);
    assign idx   = fica_dono ? dono : vencedor;

    always_comb begin
        ack           = '0;
        carregar_data = grant;
        concedido     = '0;
        data_ent      = '0;
        if (grant) begin
            ack[idx]  = 1'b1;
            concedido = idx;
            data_ent  = dado_req[idx];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            estado            <= LIVRE;
            ptr               <= '0;
            dono              <= '0;
            cnt               <= '0;
            contagem_escritas <= '0;
        end else if (!fila_cheia) begin
            if (fica_dono) begin
                cnt <= cnt + 4'd1;
                if (cnt + 4'd1 == 4'(MAX_RAJADA)) begin
                    ptr    <= dono_prox;
                    estado <= LIVRE;
                end
            end else begin
                if (estado == RAJADA)
                    ptr <= dono_prox;
                if (valido) begin
                    dono <= vencedor;
                    cnt  <= 4'd1;
                    if (MAX_RAJADA == 1) begin
                        ptr    <= venc_prox;
                        estado <= LIVRE;
                    end else begin
                        estado <= RAJADA;
                    end
                end else begin
                    estado <= LIVRE;
                end
            end
            if (grant)
                contagem_escritas <= contagem_escritas + 16'd1;
        end
    end

endmodule

// File: tb/tb_fifo_arbitro_rr.sv
// Scoreboard bench: per-cycle expected writes queued by each scenario.
module tb_fifo_arbitro_rr;

    localparam int N = 4;
    localparam int W = 8;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [N-1:0]           req;
    logic [N-1:0][W-1:0]    dado_req;
    logic [N-1:0]           ack;
    logic                   fila_cheia;
    logic                   carregar_data;
    logic [W-1:0]           data_ent;
    logic [1:0]             concedido;
    logic [15:0]            contagem_escritas;

    always #5 clk = ~clk;

    fifo_arbitro_rr #(
        .N_REQ             (N),
        .LARGURA           (W),
        .MAX_RAJADA        (4)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .req               (req),
        .dado_req          (dado_req),
        .ack               (ack),
        .fila_cheia        (fila_cheia),
        .carregar_data     (carregar_data),
        .data_ent          (data_ent),
        .concedido         (concedido),
        .contagem_escritas (contagem_escritas)
    );

    typedef struct packed {
        logic       wr;
        logic [1:0] idx;
        logic [7:0] d;
    } esp_t;

    esp_t sb[$];
    int   rem[N];
    int   seq[N];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic verifica(input string tag, input logic [31:0] obs,
                            input logic [31:0] esp);
        n_cmp++;
        if (obs !== esp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, esp);
        end
    endtask

    task automatic aplica();
        for (int i = 0; i < N; i++) begin
            req[i]      = rem[i] > 0;
            dado_req[i] = 8'(i * 16 + seq[i]);
        end
    endtask

    task automatic escrita(input int idx, input int d);
        esp_t e;
        e.wr  = 1'b1;
        e.idx = 2'(idx);
        e.d   = 8'(d);
        sb.push_back(e);
    endtask

    task automatic ocioso(input int n);
        esp_t e;
        e = '0;
        repeat (n) sb.push_back(e);
    endtask

    task automatic ciclo();
        esp_t         e;
        logic [N-1:0] hs;
        aplica();
        @(negedge clk);
        if (sb.size() == 0) begin
            verifica("sb_vazio", 32'd0, 32'd1);
            e = '0;
        end else begin
            e = sb.pop_front();
        end
        verifica("carregar", carregar_data, e.wr);
        verifica("ack_sem_req", ack & ~req, 0);
        if (e.wr) begin
            verifica("concedido", concedido, e.idx);
            verifica("data_ent", data_ent, e.d);
            verifica("ack", ack, 32'd1 << e.idx);
        end else begin
            verifica("ack_ocioso", ack, 0);
            verifica("concedido_ocioso", concedido, 0);
        end
        if (rst)
            verifica("data_rst", data_ent, 0);
        hs = ack & req;
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (hs[i]) begin
                seq[i]++;
                rem[i]--;
            end
        end
    endtask

    task automatic roda(input int n);
        repeat (n) ciclo();
    endtask

    task automatic zera();
        for (int i = 0; i < N; i++) begin
            rem[i] = 0;
            seq[i] = 0;
        end
    endtask

    task automatic reinicia();
        rst = 1'b1;
        ocioso(1);
        ciclo();
        rst = 1'b0;
    endtask

    initial begin
        rst        = 1'b1;
        fila_cheia = 1'b0;
        zera();
        for (int i = 0; i < N; i++) rem[i] = 100;
        aplica();

        // reset held with every requester active
        ocioso(2);
        roda(2);
        verifica("cont_rst", contagem_escritas, 0);
        rst = 1'b0;
        zera();

        // single requester streams six words
        reinicia();
        rem[0] = 6;
        seq[0] = 1;
        for (int k = 1; k <= 6; k++) escrita(0, k);
        ocioso(1);
        roda(7);
        verifica("cont_solo", contagem_escritas, 6);

        // all four contend: bursts of four in rotation
        zera();
        reinicia();
        for (int i = 0; i < N; i++) rem[i] = 100;
        for (int k = 0; k < 16; k++) escrita(k / 4, (k / 4) * 16 + (k % 4));
        roda(16);
        verifica("cont_rr", contagem_escritas, 16);

        // FIFO full stalls a burst without losing its place
        zera();
        reinicia();
        rem[1] = 4;
        escrita(1, 8'h10);
        escrita(1, 8'h11);
        roda(2);
        fila_cheia = 1'b1;
        rem[2] = 1;
        ocioso(3);
        roda(3);
        fila_cheia = 1'b0;
        escrita(1, 8'h12);
        escrita(1, 8'h13);
        escrita(2, 8'h20);
        ocioso(1);
        roda(4);
        verifica("cont_cheia", contagem_escritas, 5);

        // owner drops: handover without a bubble
        zera();
        reinicia();
        rem[0] = 1;
        rem[2] = 2;
        rem[3] = 1;
        escrita(0, 8'h00);
        escrita(2, 8'h20);
        escrita(2, 8'h21);
        escrita(3, 8'h30);
        ocioso(1);
        roda(5);
        verifica("cont_troca", contagem_escritas, 4);

        // reset in the middle of requester 2's burst
        zera();
        reinicia();
        rem[2] = 100;
        escrita(2, 8'h20);
        escrita(2, 8'h21);
        roda(2);
        for (int i = 0; i < N; i++) rem[i] = 100;
        reinicia();
        verifica("cont_rst_rajada", contagem_escritas, 0);
        escrita(0, 8'h00);
        escrita(0, 8'h01);
        roda(2);
        verifica("cont_final", contagem_escritas, 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fifo_arbitro_rr.md
FIFO_ARBITRO_RR -- requirements
Module: fifo_arbitro_rr

Interface
REQ-001 Parameter N_REQ, 4, number of requesters (2..8).
REQ-002 Parameter LARGURA, 8, data width; equals FIFO data_ent width.
REQ-003 Parameter MAX_RAJADA, 4, max consecutive writes granted to one requester (1..15).
REQ-004 clk  in  1  single clock; all state on rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 req  in  N_REQ  per-requester write request (valid); held with data until ack.
REQ-007 dado_req  in  N_REQ x LARGURA  per-requester write data.
REQ-008 ack  out  N_REQ  one-hot; transfer occurs on an edge where req[i]&ack[i].
REQ-009 fila_cheia  in  1  FIFO full flag.
REQ-010 carregar_data  out  1  FIFO write strobe.
REQ-011 data_ent  out  LARGURA  FIFO write data.
REQ-012 concedido  out  $clog2(N_REQ)  index of current winner; valid when carregar_data=1, else 0.
REQ-013 contagem_escritas  out  16  total accepted writes, wraps 65535->0.

Function
REQ-014 The grant path shall be combinational, zero latency: ack, carregar_data, data_ent and concedido follow req/fila_cheia/state in the same cycle.
REQ-015 The block shall hold registered state: estado {LIVRE, RAJADA}, ptr (rotation start), dono (burst owner), cnt (4-bit burst count).
REQ-016 When fila_cheia=1 the block shall drive ack=0, carregar_data=0 and hold estado, ptr, dono, cnt and contagem_escritas.
REQ-017 LIVRE, fila_cheia=0, any req: winner w = first set req scanning ptr, ptr+1, ... modulo N_REQ; ack[w]=1, carregar_data=1, data_ent=dado_req[w].
REQ-018 LIVRE grant, next state: dono<=w, cnt<=1; if MAX_RAJADA=1 then ptr<=w+1 mod N_REQ and stay LIVRE, else estado<=RAJADA.
REQ-019 RAJADA, fila_cheia=0, req[dono]=1: grant dono, cnt<=cnt+1; if cnt+1=MAX_RAJADA then ptr<=dono+1 mod N_REQ, estado<=LIVRE.
REQ-020 RAJADA, fila_cheia=0, req[dono]=0: ptr<=dono+1 mod N_REQ and arbitrate in the same cycle per REQ-017/018 with scan start dono+1 (no bubble); if no req, estado<=LIVRE, no grant.
REQ-021 No req set, fila_cheia=0: no grant, state unchanged except RAJADA per REQ-020.
REQ-022 contagem_escritas shall increment by 1 on every edge with carregar_data=1.
REQ-023 At most one ack bit shall be high in any cycle; ack[i] shall never be high while req[i]=0.
REQ-024 Back-to-back cycles shall sustain one write per cycle while fila_cheia=0 and any req is set.

Reset
REQ-025 On an edge with rst=1: estado<=LIVRE, ptr<=0, dono<=0, cnt<=0, contagem_escritas<=0.
REQ-026 While rst=1, ack, carregar_data, concedido and data_ent shall be 0 regardless of req.
REQ-027 Reset mid-burst shall discard the burst; first grant after reset starts scanning at index 0.

Structure
REQ-028 Package arbitro_pkg shall hold the estado enum and default N_REQ/LARGURA/MAX_RAJADA constants.
REQ-029 Sub-module rr_prioridade (combinational rotating priority encoder: req, start index -> valid, winner index) shall be instantiated once.

Verification (MAX_RAJADA=4, N_REQ=4, LARGURA=8)
REQ-030 rst=1 two cycles with req=4'b1111 -> ack=0, carregar_data=0, contagem_escritas=0.
REQ-031 Only req[0] held 6 cycles, dado_req[0]=1..6 updated per ack -> 6 consecutive writes 1..6, ack[0] every cycle, contagem_escritas=6.
REQ-032 req=4'b1111 held 16 cycles -> concedido sequence 0,0,0,0,1,1,1,1,2,2,2,2,3,3,3,3; contagem_escritas=16.
REQ-033 req[1] alone, fila_cheia=1 after its 2nd write for 3 cycles, req[2] raised meanwhile -> 3 cycles no write, then 2 more req[1] writes, then req[2] granted.
REQ-034 req[0] drops after 1 write, req[2]=req[3]=1 -> next cycle grants 2 with no idle cycle.
REQ-035 rst pulse during RAJADA with dono=2, req=4'b1111 after reset -> first grant concedido=0.
